// File: rtl/clahe_hist_ram_ctrl_if.sv
`default_nettype none
// =============================================================================
// clahe_hist_ram_ctrl_if : pixel, histogram-stream and RAM-port bundle
// Rev 1.0
// =============================================================================
interface clahe_hist_ram_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
);
   logic              pix_valid;
   logic [ADDR_W-1:0] pix_data;
   logic              pix_ready;
   logic              clear_start;
   logic              rd_start;
   logic              busy;
   logic              done;
   logic              hist_valid;
   logic              hist_ready;
   logic [ADDR_W-1:0] hist_bin;
   logic [CNT_W-1:0]  hist_count;
   logic              hist_last;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [CNT_W-1:0]  ram_wdata;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_raddr;
   logic [CNT_W-1:0]  ram_rdata;

   modport master (
      input  pix_valid, pix_data, clear_start, rd_start, hist_ready, ram_rdata,
      output pix_ready, busy, done, hist_valid, hist_bin, hist_count, hist_last,
             ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
   );

   modport slave (
      output pix_valid, pix_data, clear_start, rd_start, hist_ready, ram_rdata,
      input  pix_ready, busy, done, hist_valid, hist_bin, hist_count, hist_last,
             ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
   );
endinterface
`default_nettype wire

// File: rtl/clahe_hist_ram_ctrl.sv
`default_nettype none
// =============================================================================
// clahe_hist_ram_ctrl : tile histogram RAM controller (accumulate/clear/readout)
// Rev 1.0
// =============================================================================
module clahe_hist_ram_ctrl #(
   parameter int ADDR_W      = 8,
   parameter int CNT_W       = 16,
   parameter int CLR_ON_READ = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   clahe_hist_ram_ctrl_if.master bus
);

   localparam logic [ADDR_W-1:0] LAST_BIN = '1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2,
      READ  = 2'd3
   } state_t;

   state_t            state;
   logic              op_clear;
   logic              done_q;

   logic              valid_s1;
   logic [ADDR_W-1:0] addr_s1;
   logic              fwd_valid;
   logic [ADDR_W-1:0] fwd_addr;
   logic [CNT_W-1:0]  fwd_data;

   logic [ADDR_W-1:0] clr_addr;
   logic [ADDR_W-1:0] iss_addr;
   logic              iss_done;
   logic              ret_valid;
   logic [ADDR_W-1:0] ret_bin;

   logic [ADDR_W-1:0] skid_bin   [2];
   logic [CNT_W-1:0]  skid_count [2];
   logic [1:0]        skid_occ;
   logic              wr_ptr;
   logic              rd_ptr;

   logic              start_any;
   logic              pix_ready_c;
   logic              accept;
   logic [CNT_W-1:0]  base;
   logic [CNT_W-1:0]  inc;
   logic [1:0]        inflight;
   logic              issue;
   logic              out_valid;
   logic [ADDR_W-1:0] out_bin;
   logic [CNT_W-1:0]  out_count;
   logic              beat;
   logic              push;
   logic              pop;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [CNT_W-1:0]  wdata;
   logic              re;
   logic [ADDR_W-1:0] raddr;

   assign start_any   = bus.clear_start | bus.rd_start;
   assign pix_ready_c = (state == ACCUM) && !start_any;
   assign accept      = bus.pix_valid && pix_ready_c;

   // READ_FIRST returns stale data when the previous cycle wrote the same bin
   assign base = (fwd_valid && (fwd_addr == addr_s1)) ? fwd_data : bus.ram_rdata;
   assign inc  = (base == CNT_MAX) ? base : base + CNT_W'(1);

   assign inflight = {1'b0, ret_valid} + skid_occ;
   assign issue    = (state == READ) && !iss_done && (inflight < 2'd2);

   // Empty skid lets returning data bypass straight to the stream outputs
   assign out_valid = ret_valid || (skid_occ != 2'd0);
   assign out_bin   = (skid_occ == 2'd0) ? ret_bin : skid_bin[rd_ptr];
   assign out_count = (skid_occ == 2'd0) ? bus.ram_rdata : skid_count[rd_ptr];
   assign beat      = out_valid && bus.hist_ready;
   assign push      = ret_valid && !((skid_occ == 2'd0) && bus.hist_ready);
   assign pop       = (skid_occ != 2'd0) && bus.hist_ready;

   always_comb begin
      re    = 1'b0;
      raddr = '0;
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      if (accept) begin
         re    = 1'b1;
         raddr = bus.pix_data;
      end else if (issue) begin
         re    = 1'b1;
         raddr = iss_addr;
      end
      if (valid_s1) begin
         we    = 1'b1;
         waddr = addr_s1;
         wdata = inc;
      end else if (state == CLEAR) begin
         we    = 1'b1;
         waddr = clr_addr;
      end else if ((CLR_ON_READ != 0) && ret_valid) begin
         we    = 1'b1;
         waddr = ret_bin;
      end
   end

   assign bus.pix_ready  = pix_ready_c;
   assign bus.busy       = (state != ACCUM);
   assign bus.done       = done_q;
   assign bus.hist_valid = out_valid;
   assign bus.hist_bin   = out_bin;
   assign bus.hist_count = out_count;
   assign bus.hist_last  = out_valid && (out_bin == LAST_BIN);
   assign bus.ram_we     = we;
   assign bus.ram_waddr  = waddr;
   assign bus.ram_wdata  = wdata;
   assign bus.ram_re     = re;
   assign bus.ram_raddr  = raddr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         op_clear  <= 1'b0;
         done_q    <= 1'b0;
         valid_s1  <= 1'b0;
         addr_s1   <= '0;
         fwd_valid <= 1'b0;
         fwd_addr  <= '0;
         fwd_data  <= '0;
         clr_addr  <= '0;
         iss_addr  <= '0;
         iss_done  <= 1'b0;
         ret_valid <= 1'b0;
         ret_bin   <= '0;
         skid_occ  <= 2'd0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         valid_s1  <= accept;
         fwd_valid <= valid_s1;
         ret_valid <= issue;
         if (accept) begin
            addr_s1 <= bus.pix_data;
         end
         if (valid_s1) begin
            fwd_addr <= addr_s1;
            fwd_data <= inc;
         end
         if (issue) begin
            ret_bin <= iss_addr;
         end

         if (push) begin
            skid_bin[wr_ptr]   <= ret_bin;
            skid_count[wr_ptr] <= bus.ram_rdata;
            wr_ptr             <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   skid_occ <= skid_occ + 2'd1;
            2'b01:   skid_occ <= skid_occ - 2'd1;
            default: skid_occ <= skid_occ;
         endcase

         case (state)
            ACCUM: begin
               if (start_any) begin
                  state    <= DRAIN;
                  op_clear <= bus.clear_start;
               end
            end
            DRAIN: begin
               state    <= op_clear ? CLEAR : READ;
               clr_addr <= '0;
               iss_addr <= '0;
               iss_done <= 1'b0;
            end
            CLEAR: begin
               clr_addr <= clr_addr + ADDR_W'(1);
               if (clr_addr == LAST_BIN) begin
                  state  <= ACCUM;
                  done_q <= 1'b1;
               end
            end
            READ: begin
               if (issue) begin
                  iss_addr <= iss_addr + ADDR_W'(1);
                  if (iss_addr == LAST_BIN) begin
                     iss_done <= 1'b1;
                  end
               end
               if (beat && (out_bin == LAST_BIN)) begin
                  state  <= ACCUM;
                  done_q <= 1'b1;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_clahe_hist_ram_ctrl.sv
`default_nettype none
// =============================================================================
// tb_clahe_hist_ram_ctrl : scoreboard bench with READ_FIRST RAM models
// Rev 1.0
// =============================================================================
module tb_clahe_hist_ram_ctrl;

   localparam int AW = 8;
   localparam int CW = 16;
   localparam int NB = 256;

   typedef struct packed {
      logic          last;
      logic [AW-1:0] bin;
      logic [CW-1:0] cnt;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          pix_valid   = 1'b0;
   logic [AW-1:0] pix_data    = '0;
   logic          clear_start = 1'b0;
   logic          rd_start    = 1'b0;
   logic          hist_ready  = 1'b0;
   logic          sel         = 1'b0;
   logic          pre_we      = 1'b0;
   logic [AW-1:0] pre_addr    = '0;
   logic [CW-1:0] pre_data    = '0;

   int total  = 0;
   int passed = 0;

   logic [CW-1:0] model [2][NB];
   logic [CW-1:0] mem0 [NB];
   logic [CW-1:0] mem1 [NB];

   clahe_hist_ram_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus0 ();
   clahe_hist_ram_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus1 ();

   assign bus0.pix_valid   = pix_valid;
   assign bus0.pix_data    = pix_data;
   assign bus0.clear_start = clear_start;
   assign bus0.rd_start    = rd_start;
   assign bus0.hist_ready  = hist_ready;
   assign bus1.pix_valid   = pix_valid;
   assign bus1.pix_data    = pix_data;
   assign bus1.clear_start = clear_start;
   assign bus1.rd_start    = rd_start;
   assign bus1.hist_ready  = hist_ready;

   clahe_hist_ram_ctrl #(.ADDR_W(AW), .CNT_W(CW), .CLR_ON_READ(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   clahe_hist_ram_ctrl #(.ADDR_W(AW), .CNT_W(CW), .CLR_ON_READ(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   // READ_FIRST, unregistered output: read data is the pre-write content
   always @(posedge clk) begin
      if (bus0.ram_re) bus0.ram_rdata <= mem0[bus0.ram_raddr];
      if (pre_we) mem0[pre_addr] <= pre_data;
      else if (bus0.ram_we) mem0[bus0.ram_waddr] <= bus0.ram_wdata;
   end

   always @(posedge clk) begin
      if (bus1.ram_re) bus1.ram_rdata <= mem1[bus1.ram_raddr];
      if (pre_we) mem1[pre_addr] <= pre_data;
      else if (bus1.ram_we) mem1[bus1.ram_waddr] <= bus1.ram_wdata;
   end

   logic          ob_pix_ready, ob_busy, ob_done, ob_hist_valid, ob_hist_last;
   logic [AW-1:0] ob_hist_bin, ob_ram_waddr, ob_ram_raddr;
   logic [CW-1:0] ob_hist_count, ob_ram_wdata;
   logic          ob_ram_we, ob_ram_re;

   always_comb begin
      ob_pix_ready  = sel ? bus1.pix_ready  : bus0.pix_ready;
      ob_busy       = sel ? bus1.busy       : bus0.busy;
      ob_done       = sel ? bus1.done       : bus0.done;
      ob_hist_valid = sel ? bus1.hist_valid : bus0.hist_valid;
      ob_hist_last  = sel ? bus1.hist_last  : bus0.hist_last;
      ob_hist_bin   = sel ? bus1.hist_bin   : bus0.hist_bin;
      ob_hist_count = sel ? bus1.hist_count : bus0.hist_count;
      ob_ram_we     = sel ? bus1.ram_we     : bus0.ram_we;
      ob_ram_waddr  = sel ? bus1.ram_waddr  : bus0.ram_waddr;
      ob_ram_wdata  = sel ? bus1.ram_wdata  : bus0.ram_wdata;
      ob_ram_re     = sel ? bus1.ram_re     : bus0.ram_re;
      ob_ram_raddr  = sel ? bus1.ram_raddr  : bus0.ram_raddr;
   end

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + CW'(1);
   endfunction

   task automatic send_pix(input logic [AW-1:0] b);
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = b;
      #1;
      total++;
      if (ob_pix_ready !== 1'b1) $display("FAIL pix_accept bin %0h: pix_ready=%0b expected 1", b, ob_pix_ready);
      else passed++;
      model[0][b] = sat_inc(model[0][b]);
      model[1][b] = sat_inc(model[1][b]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pix_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < NB; i++) begin
         @(negedge clk);
         pre_we   = 1'b1;
         pre_addr = AW'(i);
         pre_data = CW'($urandom_range(1, 65535));
      end
      @(negedge clk);
      pre_we = 1'b0;
      #1;
      total++; if (ob_pix_ready !== 1'b1) $display("FAIL rst_pix_ready: got %0b expected 1", ob_pix_ready); else passed++;
      total++; if (ob_busy !== 1'b0) $display("FAIL rst_busy: got %0b expected 0", ob_busy); else passed++;
      total++; if (ob_done !== 1'b0) $display("FAIL rst_done: got %0b expected 0", ob_done); else passed++;
      total++; if (ob_hist_valid !== 1'b0) $display("FAIL rst_hist_valid: got %0b expected 0", ob_hist_valid); else passed++;
      total++; if (ob_ram_we !== 1'b0) $display("FAIL rst_ram_we: got %0b expected 0", ob_ram_we); else passed++;
      total++; if (ob_ram_re !== 1'b0) $display("FAIL rst_ram_re: got %0b expected 0", ob_ram_re); else passed++;
      total++; if (ob_ram_waddr !== '0) $display("FAIL rst_ram_waddr: got %0h expected 0", ob_ram_waddr); else passed++;
      total++; if (ob_ram_raddr !== '0) $display("FAIL rst_ram_raddr: got %0h expected 0", ob_ram_raddr); else passed++;
      total++; if (ob_ram_wdata !== '0) $display("FAIL rst_ram_wdata: got %0h expected 0", ob_ram_wdata); else passed++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_clear(input bit with_rd, input bit with_pix);
      int nwr, bad, nre, nhv, ndone;
      @(negedge clk);
      clear_start = 1'b1;
      rd_start    = with_rd;
      pix_valid   = with_pix;
      pix_data    = 8'h44;
      #1;
      total++; if (ob_pix_ready !== 1'b0) $display("FAIL clear_start_pix_ready: got %0b expected 0", ob_pix_ready); else passed++;
      total++; if (ob_ram_re !== 1'b0) $display("FAIL clear_start_ram_re: got %0b expected 0", ob_ram_re); else passed++;
      @(negedge clk);
      clear_start = 1'b0;
      rd_start    = 1'b0;
      pix_valid   = 1'b0;
      #1;
      nwr = 0; bad = 0; nre = 0; nhv = 0; ndone = 0;
      repeat (262) begin
         if (ob_ram_we) begin
            if (ob_ram_waddr !== AW'(nwr) || ob_ram_wdata !== '0) bad++;
            nwr++;
         end
         if (ob_ram_re) nre++;
         if (ob_hist_valid) nhv++;
         if (ob_done) ndone++;
         @(negedge clk);
         #1;
      end
      total++; if (nwr != NB) $display("FAIL clear_writes: got %0d expected %0d", nwr, NB); else passed++;
      total++; if (bad != 0) $display("FAIL clear_addr_data: %0d bad writes, expected 0", bad); else passed++;
      total++; if (nre != 0) $display("FAIL clear_reads: got %0d expected 0", nre); else passed++;
      total++; if (nhv != 0) $display("FAIL clear_hist_valid: got %0d beats expected 0", nhv); else passed++;
      total++; if (ndone != 1) $display("FAIL clear_done: got %0d pulses expected 1", ndone); else passed++;
      total++; if (ob_busy !== 1'b0) $display("FAIL clear_busy_after: got %0b expected 0", ob_busy); else passed++;
      for (int i = 0; i < NB; i++) begin
         model[0][i] = '0;
         model[1][i] = '0;
      end
   endtask

   task automatic run_readout(input bit rand_ready);
      beat_t q[$];
      beat_t e;
      int k, first_k, last_k, done_k, ndone, issued, accepted, inf, max_inf, stab_bad;
      logic p_v, p_r;
      logic [AW-1:0] p_b;
      logic [CW-1:0] p_c;
      for (int i = 0; i < NB; i++) q.push_back({(i == NB - 1), AW'(i), model[sel][i]});
      @(negedge clk);
      rd_start   = 1'b1;
      hist_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      k = 0; first_k = -1; last_k = -1; done_k = -1; ndone = 0;
      issued = 0; accepted = 0; max_inf = 0; stab_bad = 0;
      p_v = 1'b0; p_r = 1'b0; p_b = '0; p_c = '0;
      while (k < 2000 && !(q.size() == 0 && last_k >= 0 && k > last_k + 1)) begin
         if (ob_ram_re) begin
            inf = issued + 1 - accepted;
            if (inf > max_inf) max_inf = inf;
            issued++;
         end
         if (p_v && !p_r && (!ob_hist_valid || ob_hist_bin !== p_b || ob_hist_count !== p_c)) stab_bad++;
         if (ob_hist_valid && first_k < 0) first_k = k;
         if (ob_done) begin
            ndone++;
            done_k = k;
         end
         if (ob_hist_valid && hist_ready) begin
            total++;
            if (q.size() == 0) begin
               $display("FAIL beat_extra: got bin %0h with no beat expected", ob_hist_bin);
            end else begin
               e = q.pop_front();
               if ({ob_hist_last, ob_hist_bin, ob_hist_count} !== e)
                  $display("FAIL beat: got bin %0h cnt %0d last %0b, expected bin %0h cnt %0d last %0b",
                           ob_hist_bin, ob_hist_count, ob_hist_last, e.bin, e.cnt, e.last);
               else passed++;
               if (q.size() == 0) last_k = k;
            end
            accepted++;
         end
         p_v = ob_hist_valid; p_r = hist_ready; p_b = ob_hist_bin; p_c = ob_hist_count;
         @(negedge clk);
         rd_start   = 1'b0;
         hist_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         k++;
      end
      total++; if (q.size() != 0) $display("FAIL readout_missing: %0d beats outstanding, expected 0", q.size()); else passed++;
      total++; if (ndone != 1) $display("FAIL readout_done_count: got %0d expected 1", ndone); else passed++;
      total++; if (done_k != last_k + 1) $display("FAIL readout_done_time: got cycle %0d expected %0d", done_k, last_k + 1); else passed++;
      total++; if (max_inf > 2) $display("FAIL readout_inflight: got %0d expected <= 2", max_inf); else passed++;
      total++; if (stab_bad != 0) $display("FAIL readout_stall_stable: %0d changes, expected 0", stab_bad); else passed++;
      if (!rand_ready) begin
         total++; if (first_k != 3) $display("FAIL readout_first_valid: got cycle %0d expected 3", first_k); else passed++;
         total++; if (last_k != first_k + NB - 1) $display("FAIL readout_rate: last at %0d expected %0d", last_k, first_k + NB - 1); else passed++;
      end
      for (int i = 0; i < NB; i++) model[1][i] = '0;
      hist_ready = 1'b0;
   endtask

   task automatic test_accum();
      logic [AW-1:0] pix [5];
      pix = '{8'h10, 8'h10, 8'h10, 8'h20, 8'h10};
      foreach (pix[i]) send_pix(pix[i]);
      idle(3);
      total++; if (model[0][8'h10] !== 16'd4) $display("FAIL model_bin10: got %0d expected 4", model[0][8'h10]); else passed++;
      run_readout(1'b0);
   endtask

   task automatic test_saturate();
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = 8'h33;
      pre_data = 16'hFFFA;
      @(negedge clk);
      pre_we = 1'b0;
      model[0][8'h33] = 16'hFFFA;
      model[1][8'h33] = 16'hFFFA;
      repeat (20) send_pix(8'h33);
      send_pix(8'h50);
      send_pix(8'h51);
      send_pix(8'h50);
      idle(1);
      send_pix(8'h50);
      idle(3);
      run_readout(1'b0);
   endtask

   task automatic test_clr_on_read();
      sel = 1'b1;
      test_clear(1'b0, 1'b0);
      repeat (3) send_pix(8'h07);
      idle(3);
      run_readout(1'b0);
      run_readout(1'b0);
      sel = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      int k, nd;
      sel        = 1'b0;
      hist_ready = 1'b1;
      @(negedge clk);
      rd_start = 1'b1;
      @(negedge clk);
      rd_start = 1'b0;
      #1;
      k = 0;
      while (k < 600 && !(ob_hist_valid && ob_hist_bin == AW'(100))) begin
         @(negedge clk);
         #1;
         k++;
      end
      total++; if (k >= 600) $display("FAIL mid_read_reach: beat 100 not seen within %0d cycles", k); else passed++;
      rst = 1'b1;
      @(negedge clk);
      #1;
      total++; if (ob_hist_valid !== 1'b0) $display("FAIL mid_rst_hist_valid: got %0b expected 0", ob_hist_valid); else passed++;
      total++; if (ob_busy !== 1'b0) $display("FAIL mid_rst_busy: got %0b expected 0", ob_busy); else passed++;
      total++; if (ob_ram_we !== 1'b0) $display("FAIL mid_rst_ram_we: got %0b expected 0", ob_ram_we); else passed++;
      rst = 1'b0;
      nd  = (ob_done === 1'b1) ? 1 : 0;
      repeat (5) begin
         @(negedge clk);
         #1;
         if (ob_done) nd++;
      end
      total++; if (nd != 0) $display("FAIL mid_rst_done: got %0d pulses expected 0", nd); else passed++;
      hist_ready = 1'b0;
      run_readout(1'b0);
   endtask

   initial begin
      test_reset();
      test_clear(1'b0, 1'b0);
      test_accum();
      run_readout(1'b1);
      test_saturate();
      test_clear(1'b1, 1'b1);
      run_readout(1'b0);
      test_clr_on_read();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
